// File: rtl/onehot_to_bin_pipe.sv
// Two-stage valid/ready pipeline: validates one-hot words and re-encodes them to a binary index.
// Illegal words (zero or multi-hot) are flagged and counted by a saturating error counter.
module onehot_to_bin_pipe #(
    parameter int ONE_HOT_W = 16,
    parameter int BIN_W     = 4,
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 valid_i,
    input  logic [ONE_HOT_W-1:0] one_hot_i,
    output logic                 ready_o,
    output logic                 valid_o,
    output logic [BIN_W-1:0]     bin_o,
    output logic                 err_o,
    input  logic                 ready_i,
    input  logic                 clr_cnt_i,
    output logic [ERR_CNT_W-1:0] err_cnt_o
);

    logic                 s1_valid_q, s1_valid_d;
    logic [ONE_HOT_W-1:0] s1_word_q, s1_word_d;
    logic                 s2_valid_q, s2_valid_d;
    logic [BIN_W-1:0]     s2_bin_q, s2_bin_d;
    logic                 s2_err_q, s2_err_d;
    logic [ERR_CNT_W-1:0] cnt_q, cnt_d;

    logic                 s2_ready;
    logic                 s1_ready;
    logic                 in_xfer;
    logic                 s1_adv;
    logic [BIN_W-1:0]     enc_bin;
    logic                 enc_zero;
    logic                 enc_multi;
    logic                 enc_err;

    // Handshake: a word moves whenever the stage ahead is empty or is itself draining this cycle.
    assign s2_ready = !s2_valid_q || ready_i;
    assign s1_ready = !s1_valid_q || s2_ready;
    assign in_xfer  = valid_i && s1_ready;
    assign s1_adv   = s1_valid_q && s2_ready;

    // Descending scan so the lowest set bit is the last one written.
    always_comb begin
        enc_bin = '0;
        for (int i = ONE_HOT_W - 1; i >= 0; i--) begin
            if (s1_word_q[i]) begin
                enc_bin = BIN_W'(i);
            end
        end
    end

    assign enc_zero  = (s1_word_q == '0);
    assign enc_multi = ((s1_word_q & (s1_word_q - ONE_HOT_W'(1))) != '0);
    assign enc_err   = enc_zero || enc_multi;

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_word_d  = s1_word_q;
        if (in_xfer) begin
            s1_valid_d = 1'b1;
            s1_word_d  = one_hot_i;
        end else if (s1_adv) begin
            s1_valid_d = 1'b0;
        end
    end

    // A bubble entering S2 clears valid but leaves bin/err at their last values.
    always_comb begin
        s2_valid_d = s2_valid_q;
        s2_bin_d   = s2_bin_q;
        s2_err_d   = s2_err_q;
        if (s2_ready) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_bin_d = enc_bin;
                s2_err_d = enc_err;
            end
        end
    end

    // Count on entry into S2 so a stalled word is counted once; clear beats increment.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_cnt_i) begin
            cnt_d = '0;
        end else if (s1_adv && enc_err && (cnt_q != '1)) begin
            cnt_d = cnt_q + ERR_CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            s1_word_q  <= '0;
            s2_valid_q <= 1'b0;
            s2_bin_q   <= '0;
            s2_err_q   <= 1'b0;
            cnt_q      <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_word_q  <= s1_word_d;
            s2_valid_q <= s2_valid_d;
            s2_bin_q   <= s2_bin_d;
            s2_err_q   <= s2_err_d;
            cnt_q      <= cnt_d;
        end
    end

    assign ready_o   = s1_ready;
    assign valid_o   = s2_valid_q;
    assign bin_o     = s2_bin_q;
    assign err_o     = s2_err_q;
    assign err_cnt_o = cnt_q;

endmodule

// File: tb/tb_onehot_to_bin_pipe.sv
// Bench for onehot_to_bin_pipe: vector table, hand-written backpressure/reset/counter sequences,
// and randomized traffic scored against an index/legality model with an expected queue.
module tb_onehot_to_bin_pipe;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid_i;
    logic [15:0] one_hot_i;
    logic        ready_o;
    logic        valid_o;
    logic [3:0]  bin_o;
    logic        err_o;
    logic        ready_i;
    logic        clr_cnt_i;
    logic [7:0]  err_cnt_o;

    int checks   = 0;
    int failures = 0;

    logic [4:0] exp_q[$];
    logic [3:0] pend_bin;
    logic       pend_err;
    bit         rand_rdy  = 1'b0;
    bit         last_in_x = 1'b0;
    bit         hold_pend = 1'b0;
    logic [4:0] hold_val;
    int         run_len   = 0;
    int         max_run   = 0;
    int         err_model = 0;

    typedef struct {
        logic [15:0] word;
        logic [3:0]  bin;
        logic        err;
    } vec_t;

    vec_t tbl[8];

    onehot_to_bin_pipe #(.ONE_HOT_W(16), .BIN_W(4), .ERR_CNT_W(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .valid_i   (valid_i),
        .one_hot_i (one_hot_i),
        .ready_o   (ready_o),
        .valid_o   (valid_o),
        .bin_o     (bin_o),
        .err_o     (err_o),
        .ready_i   (ready_i),
        .clr_cnt_i (clr_cnt_i),
        .err_cnt_o (err_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Reference: index of the lowest set bit, illegal unless exactly one bit is set.
    function automatic logic [4:0] model_enc(input logic [15:0] w);
        int idx   = 0;
        bit found = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (w[i] && !found) begin
                idx   = i;
                found = 1'b1;
            end
        end
        return {4'(idx), ($countones(w) != 1)};
    endfunction

    // One clock: inputs already driven at the falling edge; observe, score, advance.
    task automatic tick();
        bit in_x;
        bit out_x;
        if (rand_rdy) ready_i = 1'($urandom_range(0, 1));
        #1;
        if (hold_pend) begin
            chk("hold_valid", 32'(valid_o), 32'd1);
            chk("hold_data", 32'({bin_o, err_o}), 32'(hold_val));
        end
        in_x      = !reset && valid_i && ready_o;
        out_x     = !reset && valid_o && ready_i;
        hold_pend = !reset && valid_o && !ready_i;
        hold_val  = {bin_o, err_o};
        if (out_x) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL spurious_output: got %0h expected no word", {bin_o, err_o});
            end else begin
                chk("out_word", 32'({bin_o, err_o}), 32'(exp_q.pop_front()));
            end
        end
        if (in_x) begin
            exp_q.push_back({pend_bin, pend_err});
            if (pend_err && err_model < 255) err_model++;
        end
        if (clr_cnt_i) err_model = 0;
        run_len = valid_o ? run_len + 1 : 0;
        if (run_len > max_run) max_run = run_len;
        last_in_x = in_x;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send(input logic [15:0] w, input logic [3:0] b, input logic e);
        valid_i   = 1'b1;
        one_hot_i = w;
        pend_bin  = b;
        pend_err  = e;
        for (int n = 0; n < 200; n++) begin
            tick();
            if (last_in_x) break;
        end
        if (!last_in_x) begin
            checks++;
            failures++;
            $display("FAIL send_timeout: word %0h not accepted, expected acceptance", w);
        end
        valid_i   = 1'b0;
        one_hot_i = 16'($urandom);
    endtask

    task automatic drain();
        valid_i = 1'b0;
        for (int n = 0; n < 1000; n++) begin
            if (exp_q.size() == 0) break;
            tick();
        end
        chk("drain_empty", 32'(exp_q.size()), 32'd0);
        tick();
        tick();
    endtask

    initial begin
        logic [15:0] w;
        logic [4:0]  e;
        int          v;

        tbl[0] = '{16'h0000, 4'd0,  1'b1};
        tbl[1] = '{16'h0005, 4'd0,  1'b1};
        tbl[2] = '{16'h8000, 4'd15, 1'b0};
        tbl[3] = '{16'h0006, 4'd1,  1'b1};
        tbl[4] = '{16'hFFFF, 4'd0,  1'b1};
        tbl[5] = '{16'h0100, 4'd8,  1'b0};
        tbl[6] = '{16'hA000, 4'd13, 1'b1};
        tbl[7] = '{16'h0002, 4'd1,  1'b0};

        reset     = 1'b1;
        valid_i   = 1'b0;
        one_hot_i = 16'h0;
        ready_i   = 1'b1;
        clr_cnt_i = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_valid_o", 32'(valid_o), 32'd0);
        chk("rst_bin_o", 32'(bin_o), 32'd0);
        chk("rst_err_o", 32'(err_o), 32'd0);
        chk("rst_err_cnt", 32'(err_cnt_o), 32'd0);
        chk("rst_ready_o", 32'(ready_o), 32'd1);
        reset = 1'b0;

        // Legal sweep, back-to-back with the sink always ready.
        run_len = 0;
        max_run = 0;
        for (int k = 0; k < 16; k++) send(16'h1 << k, 4'(k), 1'b0);
        drain();
        chk("sweep_valid_run", 32'(max_run), 32'd16);
        chk("sweep_err_cnt", 32'(err_cnt_o), 32'd0);

        // Vector table: first three are the canonical illegal/legal trio.
        for (int i = 0; i < 3; i++) send(tbl[i].word, tbl[i].bin, tbl[i].err);
        drain();
        chk("trio_err_cnt", 32'(err_cnt_o), 32'd2);
        for (int i = 3; i < 8; i++) send(tbl[i].word, tbl[i].bin, tbl[i].err);
        drain();
        chk("table_err_cnt", 32'(err_cnt_o), 32'(err_model));

        // Backpressure: two accepts fill the pipe, then the block must stall.
        ready_i = 1'b0;
        send(16'h1 << 3, 4'd3, 1'b0);
        send(16'h1 << 7, 4'd7, 1'b0);
        valid_i   = 1'b1;
        one_hot_i = 16'h1 << 9;
        pend_bin  = 4'd9;
        pend_err  = 1'b0;
        for (int n = 0; n < 2; n++) begin
            #1;
            chk("bp_ready_o", 32'(ready_o), 32'd0);
            chk("bp_valid_o", 32'(valid_o), 32'd1);
            chk("bp_bin_o", 32'(bin_o), 32'd3);
            tick();
        end
        ready_i = 1'b1;
        send(16'h1 << 9, 4'd9, 1'b0);
        drain();

        // Saturation, idle clear, then clear colliding with an error entering S2.
        for (int n = 0; n < 300; n++) send(16'h0, 4'd0, 1'b1);
        drain();
        chk("sat_err_cnt", 32'(err_cnt_o), 32'd255);
        clr_cnt_i = 1'b1;
        tick();
        clr_cnt_i = 1'b0;
        chk("clr_idle", 32'(err_cnt_o), 32'd0);
        valid_i   = 1'b1;
        one_hot_i = 16'h0;
        pend_bin  = 4'd0;
        pend_err  = 1'b1;
        tick();
        valid_i   = 1'b0;
        clr_cnt_i = 1'b1;
        tick();
        clr_cnt_i = 1'b0;
        drain();
        chk("clr_collide", 32'(err_cnt_o), 32'd0);
        send(16'h0, 4'd0, 1'b1);
        drain();
        chk("cnt_after_clr", 32'(err_cnt_o), 32'd1);

        // Reset with both stages holding words.
        ready_i = 1'b0;
        send(16'h0, 4'd0, 1'b1);
        send(16'h1 << 7, 4'd7, 1'b0);
        reset = 1'b1;
        tick();
        chk("mid_rst_valid_o", 32'(valid_o), 32'd0);
        chk("mid_rst_err_cnt", 32'(err_cnt_o), 32'd0);
        chk("mid_rst_ready_o", 32'(ready_o), 32'd1);
        reset = 1'b0;
        exp_q.delete();
        err_model = 0;
        hold_pend = 1'b0;
        ready_i   = 1'b1;
        send(16'h1 << 5, 4'd5, 1'b0);
        drain();

        // Round trip through a decoder model with random sink readiness.
        rand_rdy = 1'b1;
        for (int n = 0; n < 400; n++) begin
            v = $urandom_range(0, 15);
            w = 16'h1 << v;
            send(w, 4'(v), 1'b0);
            if ($urandom_range(0, 3) == 0) tick();
        end
        drain();
        chk("roundtrip_err_cnt", 32'(err_cnt_o), 32'd0);

        // Mixed legal/illegal random words against the reference model.
        for (int n = 0; n < 300; n++) begin
            case ($urandom_range(0, 2))
                0:       w = 16'h1 << $urandom_range(0, 15);
                1:       w = 16'($urandom);
                default: w = 16'h0;
            endcase
            e = model_enc(w);
            send(w, e[4:1], e[0]);
        end
        drain();
        chk("random_err_cnt", 32'(err_cnt_o), 32'(err_model));
        rand_rdy = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
